// File: rtl/fft_tx_scheduler.sv
// fft_tx_scheduler
//   Sequences one FFT per accepted sample tick. When the butterfly array
//   reports completion, the 16 result bytes are captured into a shadow
//   register. They are then streamed to the SPI master, optionally preceded
//   by a sync header. Each byte uses a ready/valid handshake and is followed
//   by a fixed idle gap.
//
// Ports
//   i_Clk         system clock, rising edge
//   i_Rst_L       asynchronous active-low reset
//   i_Sample      one-cycle sample tick
//   o_Start_Calc  one-cycle start pulse to the stage-1 butterflies
//   i_Frame_DV    stage-3 completion pulse
//   i_Frame       128-bit FFT result, byte k at [8k+7:8k]
//   o_TX_Byte     byte to the SPI master, held until the next strobe
//   o_TX_DV       one-cycle send strobe
//   i_TX_Ready    SPI master ready
//   o_Busy        high whenever the sequencer is not idle
//   o_Frame_Done  one-cycle pulse as the sequencer returns to idle after a frame
//   o_Drop_Count  saturating count of ignored sample ticks
//   o_Timeout     sticky flag: an FFT completion never arrived
module fft_tx_scheduler #(
  parameter bit          HEADER_EN   = 1'b1,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5,
  parameter int unsigned GAP_CYCLES  = 100,
  parameter int unsigned FFT_TIMEOUT = 64
) (
  input  logic         i_Clk,
  input  logic         i_Rst_L,
  input  logic         i_Sample,
  output logic         o_Start_Calc,
  input  logic         i_Frame_DV,
  input  logic [127:0] i_Frame,
  output logic [7:0]   o_TX_Byte,
  output logic         o_TX_DV,
  input  logic         i_TX_Ready,
  output logic         o_Busy,
  output logic         o_Frame_Done,
  output logic [7:0]   o_Drop_Count,
  output logic         o_Timeout
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int unsigned TMR_W = $clog2(FFT_TIMEOUT);

  localparam logic [4:0]       LAST_IDX = HEADER_EN ? 5'd16 : 5'd15;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(FFT_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_SEND,
    ST_ACK_LO,
    ST_ACK_HI,
    ST_GAP
  } state_e;

  state_e             state_q,      state_d;
  logic [127:0]       shadow_q,     shadow_d;
  logic [4:0]         idx_q,        idx_d;
  logic [GAP_W-1:0]   gap_q,        gap_d;
  logic [TMR_W-1:0]   timer_q,      timer_d;
  logic               start_calc_q, start_calc_d;
  logic [7:0]         tx_byte_q,    tx_byte_d;
  logic               tx_dv_q,      tx_dv_d;
  logic               busy_q,       busy_d;
  logic               frame_done_q, frame_done_d;
  logic [7:0]         drop_q,       drop_d;
  logic               timeout_q,    timeout_d;

  logic               sample_accept;
  logic               sample_drop;
  logic [3:0]         byte_sel;
  logic [7:0]         cur_byte;

  // A tick landing in the Frame_Done cycle still belongs to the finished
  // frame, so it is dropped even though the state already reads IDLE.
  always_comb begin
    sample_accept = i_Sample && (state_q == ST_IDLE) && !frame_done_q;
    sample_drop   = i_Sample && !sample_accept;
  end

  // With the header enabled, idx 16 wraps to shadow byte 15 in 4 bits.
  always_comb begin
    byte_sel = idx_q[3:0] - 4'(HEADER_EN);
    if (HEADER_EN && (idx_q == 5'd0)) begin
      cur_byte = HEADER_BYTE;
    end else begin
      cur_byte = shadow_q[{byte_sel, 3'b000} +: 8];
    end
  end

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    timer_d      = timer_q;
    start_calc_d = 1'b0;
    tx_byte_d    = tx_byte_q;
    tx_dv_d      = 1'b0;
    frame_done_d = 1'b0;
    timeout_d    = timeout_q;
    drop_d       = drop_q;

    if (sample_drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (sample_accept) begin
          start_calc_d = 1'b1;
          timer_d      = '0;
          state_d      = ST_CALC;
        end
      end
      ST_CALC: begin
        if (i_Frame_DV) begin
          shadow_d = i_Frame;
          idx_d    = '0;
          state_d  = ST_SEND;
        end else if (timer_q == TMR_LAST) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (i_TX_Ready) begin
          tx_byte_d = cur_byte;
          tx_dv_d   = 1'b1;
          state_d   = ST_ACK_LO;
        end
      end
      ST_ACK_LO: begin
        if (!i_TX_Ready) begin
          state_d = ST_ACK_HI;
        end
      end
      ST_ACK_HI: begin
        if (i_TX_Ready) begin
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_d = gap_q - 1'b1;
        if (gap_q == GAP_W'(1)) begin
          if (idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_SEND;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q      <= ST_IDLE;
      shadow_q     <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      timer_q      <= '0;
      start_calc_q <= 1'b0;
      tx_byte_q    <= '0;
      tx_dv_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      drop_q       <= '0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      idx_q        <= idx_d;
      gap_q        <= gap_d;
      timer_q      <= timer_d;
      start_calc_q <= start_calc_d;
      tx_byte_q    <= tx_byte_d;
      tx_dv_q      <= tx_dv_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      drop_q       <= drop_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_Start_Calc = start_calc_q;
  assign o_TX_Byte    = tx_byte_q;
  assign o_TX_DV      = tx_dv_q;
  assign o_Busy       = busy_q;
  assign o_Frame_Done = frame_done_q;
  assign o_Drop_Count = drop_q;
  assign o_Timeout    = timeout_q;

endmodule

// File: tb/tb_fft_tx_scheduler.sv
// Directed bench for fft_tx_scheduler.
//   dut_a: header on,  gap 4, timeout 64 (nominal, overrun, saturation, reset)
//   dut_b: header off, gap 4, timeout 8  (headerless, timeout handling)
module tb_fft_tx_scheduler;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] frame;

  logic       sample_a, fdv_a, ready_a, stall_a, start_a, tx_dv_a, busy_a, done_a, timeout_a;
  logic [7:0] tx_byte_a, drop_a;
  logic       sample_b, fdv_b, ready_b, start_b, tx_dv_b, busy_b, done_b, timeout_b;
  logic [7:0] tx_byte_b, drop_b;

  logic mready_a = 1'b1;
  logic mready_b = 1'b1;
  int   sc_a = 0;
  int   sc_b = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] bytes_a[$];
  logic [7:0] bytes_b[$];
  int         gaps_a[$];
  int         n_start_a = 0;
  int         n_done_a  = 0;
  int         n_done_b  = 0;
  bit         armed_a   = 1'b0;
  logic       rprev_a   = 1'b1;
  int         gcnt_a    = 0;

  always #5 clk = ~clk;

  assign ready_a = mready_a & ~stall_a;
  assign ready_b = mready_b;

  fft_tx_scheduler #(
    .HEADER_EN   (1'b1),
    .HEADER_BYTE (8'hA5),
    .GAP_CYCLES  (4),
    .FFT_TIMEOUT (64)
  ) dut_a (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Sample     (sample_a),
    .o_Start_Calc (start_a),
    .i_Frame_DV   (fdv_a),
    .i_Frame      (frame),
    .o_TX_Byte    (tx_byte_a),
    .o_TX_DV      (tx_dv_a),
    .i_TX_Ready   (ready_a),
    .o_Busy       (busy_a),
    .o_Frame_Done (done_a),
    .o_Drop_Count (drop_a),
    .o_Timeout    (timeout_a)
  );

  fft_tx_scheduler #(
    .HEADER_EN   (1'b0),
    .HEADER_BYTE (8'hA5),
    .GAP_CYCLES  (4),
    .FFT_TIMEOUT (8)
  ) dut_b (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Sample     (sample_b),
    .o_Start_Calc (start_b),
    .i_Frame_DV   (fdv_b),
    .i_Frame      (frame),
    .o_TX_Byte    (tx_byte_b),
    .o_TX_DV      (tx_dv_b),
    .i_TX_Ready   (ready_b),
    .o_Busy       (busy_b),
    .o_Frame_Done (done_b),
    .o_Drop_Count (drop_b),
    .o_Timeout    (timeout_b)
  );

  // SPI master models: ready drops one cycle after the strobe, returns 8 later.
  always @(posedge clk) begin
    if (tx_dv_a) begin
      mready_a <= 1'b0;
      sc_a     <= 8;
    end else if (sc_a != 0) begin
      sc_a <= sc_a - 1;
      if (sc_a == 1) mready_a <= 1'b1;
    end
    if (tx_dv_b) begin
      mready_b <= 1'b0;
      sc_b     <= 8;
    end else if (sc_b != 0) begin
      sc_b <= sc_b - 1;
      if (sc_b == 1) mready_b <= 1'b1;
    end
  end

  // Byte capture and gap measurement (clocks between a ready rise and the
  // next strobe, minus the SEND cycle; or up to Frame_Done for the last byte).
  always @(negedge clk) begin
    if (tx_dv_a) bytes_a.push_back(tx_byte_a);
    if (tx_dv_b) bytes_b.push_back(tx_byte_b);
    if (start_a) n_start_a++;
    if (done_a)  n_done_a++;
    if (done_b)  n_done_b++;
    if (ready_a && !rprev_a) begin
      armed_a = 1'b1;
      gcnt_a  = 0;
    end else if (armed_a && tx_dv_a) begin
      gaps_a.push_back(gcnt_a - 1);
      armed_a = 1'b0;
    end else if (armed_a && done_a) begin
      gaps_a.push_back(gcnt_a);
      armed_a = 1'b0;
    end else if (armed_a) begin
      gcnt_a++;
    end
    rprev_a = ready_a;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic tick_sample(input bit on_b);
    @(posedge clk);
    #1;
    if (on_b) sample_b = 1'b1;
    else      sample_a = 1'b1;
    @(posedge clk);
    #1;
    sample_a = 1'b0;
    sample_b = 1'b0;
  endtask

  // Frame_DV sampled n edges after the current position.
  task automatic dv_after(input bit on_b, input int n);
    repeat (n - 1) @(posedge clk);
    #1;
    if (on_b) fdv_b = 1'b1;
    else      fdv_a = 1'b1;
    @(posedge clk);
    #1;
    fdv_a = 1'b0;
    fdv_b = 1'b0;
  endtask

  task automatic wait_done(input bit on_b, input int max_cycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      @(negedge clk);
      seen = on_b ? done_b : done_a;
    end
    check(on_b ? "done_b_seen" : "done_a_seen", 32'(seen), 1);
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 16; k++) frame[8*k +: 8] = 8'h10 + 8'(k);
  endtask

  task automatic check_frame_a(input string tag);
    check({tag, "_count"}, 32'(bytes_a.size()), 17);
    for (int k = 0; k < bytes_a.size() && k < 17; k++) begin
      check({tag, "_byte"}, 32'(bytes_a[k]), (k == 0) ? 32'hA5 : 32'h10 + 32'(k - 1));
    end
  endtask

  task automatic check_frame_b(input string tag);
    check({tag, "_count"}, 32'(bytes_b.size()), 16);
    for (int k = 0; k < bytes_b.size() && k < 16; k++) begin
      check({tag, "_byte"}, 32'(bytes_b[k]), 32'h10 + 32'(k));
    end
  endtask

  initial begin
    bit hit;
    rst_n    = 1'b0;
    sample_a = 1'b0;
    sample_b = 1'b0;
    fdv_a    = 1'b0;
    fdv_b    = 1'b0;
    stall_a  = 1'b0;
    frame    = '0;

    // Reset state
    #2;
    check("rst_tx_dv",   32'(tx_dv_a),   0);
    check("rst_tx_byte", 32'(tx_byte_a), 0);
    check("rst_busy",    32'(busy_a),    0);
    check("rst_start",   32'(start_a),   0);
    check("rst_done",    32'(done_a),    0);
    check("rst_drop",    32'(drop_a),    0);
    check("rst_timeout", 32'(timeout_a), 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Nominal frame with header
    load_ramp();
    bytes_a.delete(); gaps_a.delete(); n_start_a = 0; n_done_a = 0;
    tick_sample(1'b0);
    check("nom_start_pulse", 32'(start_a), 1);
    check("nom_busy_calc",   32'(busy_a),  1);
    @(posedge clk); #1;
    check("nom_start_single", 32'(start_a), 0);
    dv_after(1'b0, 8);
    check("nom_busy_send", 32'(busy_a),  1);
    check("nom_no_dv_yet", 32'(tx_dv_a), 0);
    @(posedge clk); #1;
    check("nom_first_dv",   32'(tx_dv_a),   1);
    check("nom_first_byte", 32'(tx_byte_a), 32'hA5);
    wait_done(1'b0, 1000);
    check("nom_busy_at_done", 32'(busy_a), 0);
    @(posedge clk); #1;
    check("nom_done_single", 32'(done_a),    0);
    check("nom_byte_held",   32'(tx_byte_a), 32'h1F);
    check_frame_a("nom");
    check("nom_gap_count", 32'(gaps_a.size()), 17);
    for (int k = 0; k < gaps_a.size(); k++) check("nom_gap_len", 32'(gaps_a[k]), 4);
    check("nom_done_count", 32'(n_done_a),  1);
    check("nom_start_count", 32'(n_start_a), 1);
    check("nom_drop",        32'(drop_a),    0);

    // Overrun: two ticks mid-frame (one with a stray Frame_DV), one in the done cycle
    bytes_a.delete(); n_start_a = 0; n_done_a = 0;
    tick_sample(1'b0);
    dv_after(1'b0, 9);
    repeat (40) @(posedge clk);
    tick_sample(1'b0);
    check("ovr_no_start1", 32'(start_a), 0);
    check("ovr_drop1",     32'(drop_a),  1);
    frame = {16{8'hEE}};
    repeat (40) @(posedge clk);
    #1; sample_a = 1'b1; fdv_a = 1'b1;
    @(posedge clk); #1; sample_a = 1'b0; fdv_a = 1'b0;
    check("ovr_drop2", 32'(drop_a), 2);
    wait_done(1'b0, 1000);
    sample_a = 1'b1;
    @(posedge clk); #1; sample_a = 1'b0;
    check("ovr_no_start_done", 32'(start_a), 0);
    check("ovr_idle_after",    32'(busy_a),  0);
    check("ovr_drop3",         32'(drop_a),  3);
    repeat (3) @(posedge clk); #1;
    check("ovr_still_idle",  32'(busy_a),    0);
    check("ovr_start_count", 32'(n_start_a), 1);
    check_frame_a("ovr");

    // Saturation: 300 more dropped ticks while the link is stalled
    load_ramp();
    bytes_a.delete(); n_start_a = 0; n_done_a = 0;
    tick_sample(1'b0);
    dv_after(1'b0, 9);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk); #1;
      hit = (bytes_a.size() >= 2);
    end
    check("sat_two_bytes", 32'(hit), 1);
    stall_a = 1'b1;
    @(posedge clk); #1; sample_a = 1'b1;
    repeat (251) @(posedge clk); #1;
    check("sat_drop_254", 32'(drop_a), 254);
    @(posedge clk); #1;
    check("sat_drop_255", 32'(drop_a), 255);
    repeat (48) @(posedge clk); #1;
    sample_a = 1'b0;
    check("sat_drop_hold", 32'(drop_a), 255);
    check("sat_busy",      32'(busy_a), 1);
    stall_a = 1'b0;
    wait_done(1'b0, 1000);
    @(posedge clk); #1;
    check("sat_start_count", 32'(n_start_a), 1);
    check_frame_a("sat");

    // Reset in the middle of a frame, right on the strobe of byte 5
    bytes_a.delete();
    tick_sample(1'b0);
    dv_after(1'b0, 9);
    hit = 1'b0;
    for (int i = 0; i < 1000 && !hit; i++) begin
      @(negedge clk);
      hit = tx_dv_a && (tx_byte_a == 8'h14);
    end
    check("mid_byte5_seen", 32'(hit), 1);
    rst_n = 1'b0;
    #1;
    check("mid_tx_dv",   32'(tx_dv_a),   0);
    check("mid_tx_byte", 32'(tx_byte_a), 0);
    check("mid_busy",    32'(busy_a),    0);
    check("mid_drop",    32'(drop_a),    0);
    check("mid_done",    32'(done_a),    0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    bytes_a.delete(); n_start_a = 0; n_done_a = 0;
    tick_sample(1'b0);
    check("mid_restart", 32'(start_a), 1);
    dv_after(1'b0, 9);
    wait_done(1'b0, 1000);
    @(posedge clk); #1;
    check_frame_a("mid");
    check("mid_timeout", 32'(timeout_a), 0);

    // Headerless frame
    bytes_b.delete(); n_done_b = 0;
    tick_sample(1'b1);
    check("hdr0_start", 32'(start_b), 1);
    dv_after(1'b1, 4);
    check("hdr0_busy", 32'(busy_b), 1);
    wait_done(1'b1, 1000);
    @(posedge clk); #1;
    check_frame_b("hdr0");
    check("hdr0_timeout", 32'(timeout_b), 0);

    // Frame_DV on the last permitted CALC clock wins over the timeout
    bytes_b.delete();
    tick_sample(1'b1);
    dv_after(1'b1, 8);
    check("race_busy",    32'(busy_b),    1);
    check("race_timeout", 32'(timeout_b), 0);
    wait_done(1'b1, 1000);
    @(posedge clk); #1;
    check_frame_b("race");
    check("race_timeout_end", 32'(timeout_b), 0);

    // Timeout: Frame_DV never comes
    bytes_b.delete();
    tick_sample(1'b1);
    check("to_start", 32'(start_b), 1);
    repeat (7) @(posedge clk); #1;
    check("to_busy_before",    32'(busy_b),    1);
    check("to_timeout_before", 32'(timeout_b), 0);
    @(posedge clk); #1;
    check("to_timeout_set", 32'(timeout_b), 1);
    check("to_idle",        32'(busy_b),    0);
    check("to_no_done",     32'(done_b),    0);
    @(posedge clk); #1;
    fdv_b = 1'b1;
    @(posedge clk); #1;
    fdv_b = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("to_late_dv_idle",  32'(busy_b),         0);
    check("to_late_dv_bytes", 32'(bytes_b.size()), 0);
    tick_sample(1'b1);
    check("to_restart",      32'(start_b),   1);
    check("to_sticky_early", 32'(timeout_b), 1);
    dv_after(1'b1, 4);
    wait_done(1'b1, 1000);
    @(posedge clk); #1;
    check_frame_b("to_restart");
    check("to_sticky_end", 32'(timeout_b), 1);
    check("to_drop",       32'(drop_b),    0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
